// File: rtl/lab3_vector_checker_pkg.sv
// Shared types and golden reference for the lab-3 gate network checker.
// Pure declarations: no state, no timing, no flow control.
package lab3_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} chk_state_t;

  localparam int NUM_VECTORS = 8;

  // Returns {x,y}; y = ~(a&b) ^ (a|b) masked by (a|b) collapses to a&b.
  function automatic logic [1:0] golden(input logic a, input logic b, input logic c);
    return {~c ^ (a | b), a & b};
  endfunction

endpackage

// File: rtl/lab3_vector_checker_golden.sv
// Combinational golden model of the lab-3 network: {a,b,c} -> {x,y}.
// Zero latency, no flow control.
module lab3_golden_model
  import lab3_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic x_o,
  output logic y_o
);

  assign {x_o, y_o} = golden(a_i, b_i, c_i);

endmodule

// File: rtl/lab3_vector_checker.sv
// Sweeps all 8 {a,b,c} vectors into the network, holds each SETTLE_CYCLES, then checks x,y.
// Run takes 8*(SETTLE_CYCLES+1) cycles after start; start is ignored unless idle.
module lab3_vector_checker
  import lab3_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_c,
  input  logic       dut_x,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_VECTORS - 1);

  chk_state_t    state_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    drv_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [3:0]    err_q;
  logic [3:0]    err_d;
  logic [2:0]    ffvec_q;
  logic          ffv_q;
  logic          gold_x;
  logic          gold_y;
  logic          mismatch;

  lab3_golden_model u_golden (
    .a_i (idx_q[2]),
    .b_i (idx_q[1]),
    .c_i (idx_q[0]),
    .x_o (gold_x),
    .y_o (gold_y)
  );

  assign mismatch = (dut_x != gold_x) || (dut_y != gold_y);
  assign err_d    = err_q + {3'b000, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffvec_q <= '0;
      ffv_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            drv_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffvec_q <= '0;
            ffv_q   <= 1'b0;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch && !ffv_q) begin
            ffvec_q <= idx_q;
            ffv_q   <= 1'b1;
          end
          // Outputs of the DONE cycle are registered on the way in.
          if (idx_q == IDX_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 4'd0);
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 3'd1;
            drv_q   <= idx_q + 3'd1;
            state_q <= DRIVE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {drv_a, drv_b, drv_c} = drv_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_lab3_vector_checker.sv
// Table-driven bench for lab3_vector_checker with a faulty-network model and run scoreboard.
module tb_lab3_vector_checker;

  typedef struct {
    int       sel;      // 0: default settle, 1: settle of one cycle
    int       mode;     // network behaviour
    int       exp_err;
    bit [2:0] exp_ffvec;
    bit       exp_ffv;
    bit       exp_pass;
    int       exp_cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   sel = 0;
  int   mode = 0;
  logic rnd_x = 1'b0;
  logic rnd_y = 1'b0;

  logic       a0, b0, c0, x0, y0, busy0, done0, pass0, ffv0;
  logic [3:0] err0;
  logic [2:0] ffvec0;
  logic       a1, b1, c1, x1, y1, busy1, done1, pass1, ffv1;
  logic [3:0] err1;
  logic [2:0] ffvec1;
  logic       start0, start1;

  logic       s_busy, s_done, s_pass, s_ffv;
  logic [3:0] s_err;
  logic [2:0] s_ffvec, s_drv;

  int   cmp_n = 0;
  int   fail_n = 0;
  rec_t tbl[7];
  rec_t sbq[$];

  always #5 clk = ~clk;

  lab3_vector_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .drv_a(a0), .drv_b(b0), .drv_c(c0), .dut_x(x0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffvec0), .first_fail_valid(ffv0)
  );

  lab3_vector_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .drv_a(a1), .drv_b(b1), .drv_c(c1), .dut_x(x1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffvec1), .first_fail_valid(ffv1)
  );

  // Reference network from a hand-derived truth table, then the selected fault.
  function automatic logic [1:0] net(input logic [2:0] v, input int m, input logic rx, input logic ry);
    logic [7:0] xt;
    logic [7:0] yt;
    logic       x;
    logic       y;
    xt = 8'b1010_1001;  // bit v = x for vector v: 1,0,0,1,0,1,0,1
    yt = 8'b1100_0000;  // y only for 110 and 111
    x  = xt[v];
    y  = yt[v];
    case (m)
      1: y = 1'b0;
      2: x = ~x;
      3: x = 1'b1;
      4: y = 1'b1;
      7: begin x = rx; y = ry; end
      default: ;
    endcase
    return {x, y};
  endfunction

  assign {x0, y0} = net({a0, b0, c0}, mode, rnd_x, rnd_y);
  assign {x1, y1} = net({a1, b1, c1}, mode, rnd_x, rnd_y);
  assign start0 = start & (sel == 0);
  assign start1 = start & (sel == 1);

  always_comb begin
    s_busy  = (sel == 1) ? busy1  : busy0;
    s_done  = (sel == 1) ? done1  : done0;
    s_pass  = (sel == 1) ? pass1  : pass0;
    s_ffv   = (sel == 1) ? ffv1   : ffv0;
    s_err   = (sel == 1) ? err1   : err0;
    s_ffvec = (sel == 1) ? ffvec1 : ffvec0;
    s_drv   = (sel == 1) ? {a1, b1, c1} : {a0, b0, c0};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_dut"},  {a0, b0, c0, busy0, done0, pass0, err0, ffvec0, ffv0}, 0);
    check({name, "_dut1"}, {a1, b1, c1, busy1, done1, pass1, err1, ffvec1, ffv1}, 0);
  endtask

  // Launch a run; optional start pulse mid-run, start held in DONE, or reset at a given cycle.
  task automatic run(input rec_t r, input int pulse_at, input bit start_in_done, input int rst_at);
    rec_t e;
    int   cyc;
    mode = r.mode;
    sel  = r.sel;
    @(negedge clk);
    start = 1'b1;
    if (rst_at == 0) sbq.push_back(r);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", s_busy, 1);
    check("results_cleared", {s_err, s_ffv, s_pass}, 0);
    while (!s_done && cyc < 200) begin
      if (sel == 1) check("drv_hold_2cyc", s_drv, 32'((cyc - 1) / 2));
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_cycle", cyc, r.exp_cyc);
    check("busy_in_done", s_busy, 0);
    check("drv_last_vec", s_drv, 7);
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      check("err_count", s_err, e.exp_err);
      check("first_fail_valid", s_ffv, e.exp_ffv);
      if (e.exp_ffv) check("first_fail_vec", s_ffvec, e.exp_ffvec);
      check("pass", s_pass, e.exp_pass);
    end
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    check("done_one_pulse", s_done, 0);
    check("no_restart_from_done", s_busy, 0);
    check("results_hold", {s_err, s_pass}, {r.exp_err[3:0], r.exp_pass});
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 3'b000, 1'b0, 1'b1, 25};
    tbl[1] = '{0, 1, 2, 3'b110, 1'b1, 1'b0, 25};
    tbl[2] = '{0, 2, 8, 3'b000, 1'b1, 1'b0, 25};
    tbl[3] = '{0, 3, 4, 3'b001, 1'b1, 1'b0, 25};
    tbl[4] = '{0, 4, 6, 3'b000, 1'b1, 1'b0, 25};
    tbl[5] = '{1, 0, 0, 3'b000, 1'b0, 1'b1, 17};
    tbl[6] = '{1, 1, 2, 3'b110, 1'b1, 1'b0, 17};

    // Reset held with random inputs, then released with start low.
    mode = 7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      sel   = int'($urandom_range(0, 1));
      rnd_x = 1'($urandom_range(0, 1));
      rnd_y = 1'($urandom_range(0, 1));
      check_all_zero("in_reset");
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all_zero("idle_no_start");
    end

    for (int i = 0; i < 7; i++) run(tbl[i], 0, 1'b0, 0);

    // Start pulsed mid-run and again while in DONE: neither restarts.
    run(tbl[0], 10, 1'b1, 0);
    // Failing run, then reset during vector 4, then a clean run.
    run(tbl[2], 0, 1'b0, 0);
    run(tbl[0], 0, 1'b0, 14);
    check_all_zero("after_reset");
    run(tbl[0], 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
